// File: rtl/fi_pkg.sv
// Shared types and constants for the fault-injection controller.
package fi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARMED,
      INJECT,
      WAIT_DET,
      DONE
   } fi_state_e;

   typedef enum logic [1:0] {
      MODE_FLIP     = 2'd0,
      MODE_PATTERN  = 2'd1,
      MODE_ZERO     = 2'd2,
      MODE_FLIP_ALT = 2'd3
   } fi_mode_e;

   localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
   localparam logic [31:0] DEFAULT_SEED = 32'hACE1_0001;

   // Replacement instruction words: mul, srai, blt
   localparam logic [31:0] DEFAULT_PATTERNS [3] = '{32'h02A5_0533, 32'h4015_5513, 32'hFEA0_48E3};

endpackage

// File: rtl/fi_lfsr.sv
// Galois LFSR (right-shifting) with synchronous reset to a non-zero seed.
module fi_lfsr
   import fi_pkg::*;
#(
   parameter int               WIDTH = 32,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(LFSR_POLY),
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             advance_i,
   output logic [WIDTH-1:0] state_o
);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_o <= SEED;
      end else if (advance_i) begin
         state_o <= (state_o >> 1) ^ (state_o[0] ? POLY : '0);
      end
   end

   assert property (@(posedge clk_i) disable iff (rst_i) state_o != '0);

endmodule

// File: rtl/fault_inject_ctrl.sv
// Fault-injection controller: corrupts one fetch channel per injection and
// tallies detected / missed faults per campaign against the FT-manager flag.
module fault_inject_ctrl
   import fi_pkg::*;
#(
   parameter int          N_CH               = 2,
   parameter int          DATA_W             = 32,
   parameter int          ADDR_W             = 32,
   parameter int          MAX_FAULTS         = 10,
   parameter int          DET_TIMEOUT        = 16,
   parameter int          NUM_PAT            = 3,
   parameter logic [31:0] PATTERNS [NUM_PAT] = DEFAULT_PATTERNS,
   parameter logic [31:0] SEED               = DEFAULT_SEED,
   parameter int          CNT_W              = 8,
   localparam int         CH_W               = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     enable_i,
   input  logic                     start_i,
   input  logic [1:0]               mode_i,
   input  logic [7:0]               prob_i,
   input  logic [ADDR_W-1:0]        addr_limit_i,
   input  logic [ADDR_W-1:0]        addr_i,
   input  logic [N_CH*DATA_W-1:0]   data_i,
   output logic [N_CH*DATA_W-1:0]   data_o,
   input  logic                     error_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic [CNT_W-1:0]         inj_cnt_o,
   output logic [CNT_W-1:0]         det_cnt_o,
   output logic [CNT_W-1:0]         miss_cnt_o,
   output logic [CH_W-1:0]          last_ch_o
);

   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int PAT_W = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;
   localparam int TMR_W = (DET_TIMEOUT > 1) ? $clog2(DET_TIMEOUT) : 1;

   fi_state_e         state, next_state;
   logic [31:0]       lfsr;
   logic              lfsr_unused;
   logic [CH_W-1:0]   sel_ch;
   logic [BIT_W-1:0]  sel_bit;
   logic [PAT_W-1:0]  sel_pat;
   logic [TMR_W-1:0]  timer;
   logic [CNT_W-1:0]  inj_inc;
   logic              eligible, last_inj, at_max;
   logic              do_clear, do_capture, do_det, do_miss;
   logic [DATA_W-1:0] clean_word, bad_word;
   int                diff_cnt;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   fi_lfsr #(.WIDTH(32), .POLY(LFSR_POLY), .SEED(SEED)) u_lfsr (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .advance_i (state != IDLE),
      .state_o   (lfsr)
   );

   // Not every LFSR bit feeds a selector for small N_CH / DATA_W.
   assign lfsr_unused = ^lfsr;

   assign eligible = (addr_i < addr_limit_i) && ((prob_i == 8'hFF) || (lfsr[7:0] < prob_i));
   assign inj_inc  = sat_inc(inj_cnt_o);
   assign last_inj = (inj_inc == CNT_W'(MAX_FAULTS));
   assign at_max   = (inj_cnt_o == CNT_W'(MAX_FAULTS));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Dropping enable_i aborts to IDLE, but an INJECT cycle still gets accounted.
   always_comb begin
      next_state = state;
      do_clear   = 1'b0;
      do_capture = 1'b0;
      do_det     = 1'b0;
      do_miss    = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start_i && enable_i) begin
               next_state = ARMED;
               do_clear   = 1'b1;
            end
         end
         ARMED: begin
            if (eligible) begin
               next_state = INJECT;
               do_capture = 1'b1;
            end
         end
         INJECT: begin
            if (error_i) begin
               do_det     = 1'b1;
               next_state = last_inj ? DONE : ARMED;
            end else begin
               next_state = WAIT_DET;
            end
         end
         WAIT_DET: begin
            if (error_i) begin
               do_det     = 1'b1;
               next_state = at_max ? DONE : ARMED;
            end else if (timer == TMR_W'(DET_TIMEOUT - 1)) begin
               do_miss    = 1'b1;
               next_state = at_max ? DONE : ARMED;
            end
         end
         default: next_state = IDLE;
      endcase
      if (!enable_i) begin
         next_state = IDLE;
         do_clear   = 1'b0;
         do_capture = 1'b0;
         if (state != INJECT) begin
            do_det  = 1'b0;
            do_miss = 1'b0;
         end
      end
   end

   always_comb begin
      clean_word = data_i[int'(sel_ch) * DATA_W +: DATA_W];
      case (fi_mode_e'(mode_i))
         MODE_PATTERN: bad_word = DATA_W'(PATTERNS[sel_pat]);
         MODE_ZERO:    bad_word = '0;
         default:      bad_word = clean_word ^ (DATA_W'(1) << sel_bit);
      endcase
      data_o = data_i;
      if (state == INJECT) begin
         data_o[int'(sel_ch) * DATA_W +: DATA_W] = bad_word;
      end
      busy_o = (state == ARMED) || (state == INJECT) || (state == WAIT_DET);
      done_o = (state == DONE);
   end

   // Selectors are frozen when an injection is committed so INJECT sees a stable target.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         inj_cnt_o  <= '0;
         det_cnt_o  <= '0;
         miss_cnt_o <= '0;
         last_ch_o  <= '0;
         timer      <= '0;
         sel_ch     <= '0;
         sel_bit    <= '0;
         sel_pat    <= '0;
      end else begin
         if (do_clear) begin
            inj_cnt_o  <= '0;
            det_cnt_o  <= '0;
            miss_cnt_o <= '0;
         end else begin
            if (state == INJECT) begin
               inj_cnt_o <= inj_inc;
               last_ch_o <= sel_ch;
            end
            if (do_det) begin
               det_cnt_o <= sat_inc(det_cnt_o);
            end
            if (do_miss) begin
               miss_cnt_o <= sat_inc(miss_cnt_o);
            end
         end
         if (state == INJECT) begin
            timer <= '0;
         end else if (state == WAIT_DET) begin
            timer <= timer + 1'b1;
         end
         if (do_capture) begin
            sel_ch  <= (N_CH > 1) ? lfsr[8 +: CH_W] : '0;
            sel_bit <= BIT_W'(32'(lfsr[16 +: BIT_W]) % DATA_W);
            sel_pat <= PAT_W'(32'(lfsr[31:24]) % NUM_PAT);
         end
      end
   end

   always_comb begin
      diff_cnt = 0;
      for (int c = 0; c < N_CH; c++) begin
         if (data_o[c*DATA_W +: DATA_W] != data_i[c*DATA_W +: DATA_W]) begin
            diff_cnt = diff_cnt + 1;
         end
      end
   end

   assert property (@(posedge clk_i) disable iff (rst_i) diff_cnt <= 1);
   assert property (@(posedge clk_i) disable iff (rst_i)
      ({1'b0, det_cnt_o} + {1'b0, miss_cnt_o}) <= {1'b0, inj_cnt_o});

endmodule
